// File: rtl/ramp_adc_sequencer.sv
// ramp_adc_sequencer: single-slope ADC ramp controller with ascending round-robin channel scan.
// Define RAMP_ADC_AVG4_EN to average four back-to-back conversions per channel.
module ramp_adc_sequencer #(
  parameter int DAC_W      = 8,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = $clog2(NUM_CH),
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              capture_en,
  input  logic              comparator_lvl,
  output logic [DAC_W-1:0]  dac_code,
  output logic              dac_load,
  output logic [CH_W-1:0]   ch_sel,
  output logic              busy,
  output logic              result_valid,
  output logic [DAC_W-1:0]  result_data,
  output logic [CH_W-1:0]   result_ch,
  output logic              overrange
);
  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [DAC_W-1:0] FS = '1;
  typedef enum logic [1:0] {IDLE, SELECT, STEP, EMIT} state_t;
  state_t            state;
  logic [NUM_CH-1:0] mask;
  logic [CNT_W-1:0]  cnt;
  logic [DAC_W-1:0]  res_q, conv_code, fin_res;
  logic              ovr_q, last, conv_done, conv_ovr, has_nxt, fin_emit, fin_ovr;
  logic [CH_W-1:0]   first_ch, nxt_ch;
`ifdef RAMP_ADC_AVG4_EN
  logic [DAC_W+1:0]  acc, sum;
  logic [1:0]        rep;
  logic              oacc;
`endif
  always_comb begin
    last      = cnt == CNT_W'(SETTLE_CYC - 1);
    conv_done = state == SELECT ? last && !comparator_lvl
                                : state == STEP && (capture_en || (last && dac_code == FS));
    conv_code = state == STEP ? dac_code : '0;
    conv_ovr  = state == STEP && !capture_en;
    first_ch  = '0;
    nxt_ch    = '0;
    has_nxt   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_enable[i]) first_ch = CH_W'(i);
      if (mask[i] && i > int'(ch_sel)) begin
        nxt_ch  = CH_W'(i);
        has_nxt = 1'b1;
      end
    end
`ifdef RAMP_ADC_AVG4_EN
    sum      = acc + (DAC_W + 2)'(conv_code);
    fin_emit = rep == 2'd3;
    fin_res  = sum[DAC_W+1:2];
    fin_ovr  = oacc | conv_ovr;
`else
    fin_emit = 1'b1;
    fin_res  = conv_code;
    fin_ovr  = conv_ovr;
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      mask         <= '0;
      cnt          <= '0;
      res_q        <= '0;
      ovr_q        <= 1'b0;
      dac_code     <= '0;
      dac_load     <= 1'b0;
      ch_sel       <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_ch    <= '0;
      overrange    <= 1'b0;
`ifdef RAMP_ADC_AVG4_EN
      acc          <= '0;
      rep          <= '0;
      oacc         <= 1'b0;
`endif
    end else begin
      dac_load     <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE: if (start && |ch_enable) begin
          mask     <= ch_enable;
          ch_sel   <= first_ch;
          busy     <= 1'b1;
          dac_code <= '0;
          dac_load <= 1'b1;
          cnt      <= '0;
          state    <= SELECT;
`ifdef RAMP_ADC_AVG4_EN
          acc      <= '0;
          rep      <= '0;
          oacc     <= 1'b0;
`endif
        end
        SELECT, STEP: begin
          if (conv_done) begin
            res_q <= fin_res;
            ovr_q <= fin_ovr;
`ifdef RAMP_ADC_AVG4_EN
            acc   <= sum;
            oacc  <= fin_ovr;
            rep   <= rep + 2'd1;
`endif
            if (fin_emit) state <= EMIT;
            else begin
              state    <= SELECT;
              dac_code <= '0;
              dac_load <= 1'b1;
              cnt      <= '0;
            end
          end else if (!last) cnt <= cnt + 1'b1;
          else begin
            state    <= STEP;
            dac_code <= state == SELECT ? DAC_W'(1) : dac_code + 1'b1;
            dac_load <= 1'b1;
            cnt      <= '0;
          end
        end
        EMIT: begin
          result_valid <= 1'b1;
          result_data  <= res_q;
          result_ch    <= ch_sel;
          overrange    <= ovr_q;
          dac_code     <= '0;
          dac_load     <= 1'b1;
          cnt          <= '0;
          ch_sel       <= has_nxt ? nxt_ch : ch_sel;
          state        <= has_nxt ? SELECT : IDLE;
          busy         <= has_nxt;
`ifdef RAMP_ADC_AVG4_EN
          acc          <= '0;
          rep          <= '0;
          oacc         <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ramp_adc_sequencer.md
Name: ramp_adc_sequencer

Overview:
- Single-slope (ramp) ADC conversion controller with a round-robin channel scheduler.
- Steps an external DAC ramp code up from zero for each enabled analogue channel.
- Ends each step when the synchronous falling-edge pulse from the comparator capture block fires, or when the ramp reaches full scale.
- Sits between the comparator capture block and the DAC/analogue-mux drivers, and presents one result per channel to downstream logic.

Parameters:
- DAC_W, 8: DAC code width; full scale = 2^DAC_W-1.
- NUM_CH, 4: number of analogue mux channels (2..16).
- CH_W, $clog2(NUM_CH): channel index width (derived).
- SETTLE_CYC, 4: clocks per ramp step and per channel-select settle (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request one scan of enabled channels; sampled in IDLE only.
- ch_enable  in  NUM_CH  channel enable mask; latched on accepted start.
- capture_en  in  1  1-clk pulse, comparator falling edge (ramp crossed input).
- comparator_lvl  in  1  comparator output level, already synchronous to clk.
- dac_code  out  DAC_W  ramp code driven to DAC.
- dac_load  out  1  1-clk strobe when dac_code changes.
- ch_sel  out  CH_W  analogue mux select.
- busy  out  1  high from accepted start until scan completes.
- result_valid  out  1  1-clk pulse, result fields valid.
- result_data  out  DAC_W  converted code.
- result_ch  out  CH_W  channel of result.
- overrange  out  1  qualified by result_valid; ramp hit full scale with no capture.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0: dac_code, dac_load, ch_sel, busy, result_valid, result_data, result_ch, overrange. Latched mask 0. Reset mid-conversion abandons the scan; no result is emitted.
- States: IDLE, SELECT, STEP, EMIT.
- IDLE:
  - start=1 with ch_enable!=0: latch mask; go to SELECT on lowest enabled channel; busy=1 next cycle.
  - start with ch_enable==0: ignored; stay IDLE, busy stays 0.
- SELECT:
  - On entry, same edge: ch_sel=channel, dac_code=0, dac_load=1 for that cycle only.
  - Hold SETTLE_CYC cycles; capture_en is ignored (mux glitches).
  - Final SELECT cycle with comparator_lvl==0 (input at/below code 0): result_data=0, overrange=0, go to EMIT.
  - Otherwise go to STEP at code 1: dac_code=1, dac_load=1.
- STEP: window of SETTLE_CYC cycles per code. Counter reloads on each dac_load.
  - capture_en=1 in any window cycle: result_data=current dac_code, overrange=0, go to EMIT immediately.
  - Window expires, dac_code < full scale: dac_code+1, dac_load pulse, new window.
  - Window expires, dac_code == full scale: result_data=full scale, overrange=1, go to EMIT.
  - capture_en in the same cycle as window expiry: capture wins.
- EMIT:
  - One cycle: result_valid=1, result_ch=channel. result_data, result_ch and overrange hold until the next result.
  - Next state: SELECT on the next higher enabled channel in the latched mask.
  - If none remains: IDLE, busy=0 same edge, dac_code=0, dac_load=1.
  - No wrap within a scan; each enabled channel is converted exactly once, ascending.
- start while busy: ignored. ch_enable changes mid-scan: ignored.
- Latency, capture at code k>=1: 1 (start) + SETTLE_CYC + k*SETTLE_CYC-ish window + 1 EMIT. The exact result_valid cycle equals start cycle + 1 + SETTLE_CYC + (k-1)*SETTLE_CYC + j + 1, where j = 1..SETTLE_CYC is the position of the capture within the window.
- Arithmetic: dac_code increments unsigned and never wraps past full scale.

Optional Feature:
- Macro: RAMP_ADC_AVG4_EN.
- Defined:
  - Each channel is converted 4 times back-to-back; each repeat re-enters SELECT.
  - Codes are summed in a DAC_W+2-bit accumulator.
  - Single EMIT after the 4th conversion: result_data = sum>>2 (truncate); overrange = OR of the 4 overrange flags.
  - Accumulator clears on SELECT of a new channel and on reset.
- Undefined: single conversion per channel as above; no accumulator logic synthesised.

Test Plan:
1. Reset held low, then released; start=0 -> all outputs 0, state IDLE, no dac_load for 10 cycles.
2. DAC_W=8, SETTLE_CYC=4, ch_enable=4'b0001, capture_en pulsed in 2nd window cycle of code 100 -> result_valid once, result_data=100, result_ch=0, overrange=0, busy falls same edge as IDLE entry, dac_code returns 0.
3. ch_enable=4'b1010, captures at codes 37 then 200 -> results in order ch1=37 then ch3=200, exactly 2 result_valid pulses, ch_sel sequence 1,3.
4. No capture_en, comparator_lvl=1 -> dac_code reaches 255, result_data=255, overrange=1; capture_en pulses injected during SELECT are ignored.
5. comparator_lvl=0 at end of SELECT -> result_data=0 with no STEP cycles. Reset asserted mid-STEP at code 50 -> outputs 0 immediately, no result_valid. start with ch_enable=0 -> busy stays 0.
6. RAMP_ADC_AVG4_EN defined, captures at 10, 11, 12, 14 -> single result_valid, result_data=11 (47>>2), overrange=0.
